// File: rtl/udc_pkg.sv
// Shared constants, FSM state type and bus-slice helper for the DC-link Udc collection path.
package udc_pkg;

    localparam int PHASES  = 3;
    localparam int LINKNUM = 24;
    localparam int UDC_W   = 16;
    localparam int ADDR_W  = 7;
    localparam int NLINKS  = 72;
    localparam int BUS_W   = UDC_W * LINKNUM;
    localparam int MISS_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PUBLISH = 2'd3
    } udc_state_e;

    // Link n (1-based) occupies bits [lsb+15:lsb]; link 1 sits at the top of the bus.
    function automatic int udc_slice_lsb(input int link);
        return UDC_W * (LINKNUM - link);
    endfunction

endpackage

// File: rtl/udc_bus_scheduler_if.sv
// Scheduler-side bundle: period strobe, link-receive buffer read port and published Udc buses.
interface udc_bus_scheduler_if;
    import udc_pkg::*;

    logic               sync_pulse;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [UDC_W:0]     rd_data;
    logic [BUS_W-1:0]   LinkUdcA_BUS;
    logic [BUS_W-1:0]   LinkUdcB_BUS;
    logic [BUS_W-1:0]   LinkUdcC_BUS;
    logic               bus_valid;
    logic               busy;
    logic [NLINKS-1:0]  stale_mask;
    logic               overrun;

    modport master (
        input  sync_pulse, rd_data,
        output rd_en, rd_addr, LinkUdcA_BUS, LinkUdcB_BUS, LinkUdcC_BUS,
               bus_valid, busy, stale_mask, overrun
    );

    modport slave (
        output sync_pulse, rd_data,
        input  rd_en, rd_addr, LinkUdcA_BUS, LinkUdcB_BUS, LinkUdcC_BUS,
               bus_valid, busy, stale_mask, overrun
    );

endinterface

// File: rtl/udc_link_age.sv
// Per-link freshness tracker: saturating count of consecutive periods without a fresh frame.
module udc_link_age #(
    parameter int STALE_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hit,
    input  logic fresh,
    output logic stale
);
    import udc_pkg::*;

    localparam logic [MISS_W-1:0] MISS_SAT = MISS_W'(STALE_MAX);

    logic [MISS_W-1:0] miss_r;
    logic [MISS_W-1:0] miss_nxt_s;

    // Next miss count for this link's returning word.
    always_comb begin
        miss_nxt_s = miss_r;
        if (hit) begin
            if (fresh) begin
                miss_nxt_s = {MISS_W{1'b0}};
            end else if (miss_r != MISS_SAT) begin
                miss_nxt_s = miss_r + MISS_W'(1);
            end else begin
                miss_nxt_s = miss_r;
            end
        end else begin
            miss_nxt_s = miss_r;
        end
    end

    // Miss counter register; a link is presumed stale until its first fresh frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_r <= MISS_SAT;
        end else begin
            miss_r <= miss_nxt_s;
        end
    end

    // Reports the post-update state so a capture on the publishing edge is reflected.
    assign stale = (miss_nxt_s == MISS_SAT);

endmodule

// File: rtl/udc_bus_scheduler.sv
// Collects all 72 link Udc values once per control period and publishes the packed buses atomically.
module udc_bus_scheduler #(
    parameter int LINKNUM   = 24,
    parameter int RD_LAT    = 2,
    parameter int STALE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    udc_bus_scheduler_if.master   bus
);
    import udc_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NLINKS - 1);

    udc_state_e         state_r;
    logic [ADDR_W-1:0]  addr_r;
    logic               rd_en_r;
    logic [RD_LAT-1:0]  pipe_vld_r;
    logic [ADDR_W-1:0]  pipe_addr_r [RD_LAT];
    logic [UDC_W-1:0]   shadow_r     [NLINKS];
    logic [UDC_W-1:0]   shadow_nxt_s [NLINKS];
    logic [BUS_W-1:0]   bus_r        [PHASES];
    logic [BUS_W-1:0]   bus_nxt_s    [PHASES];
    logic [NLINKS-1:0]  hit_s;
    logic [NLINKS-1:0]  stale_nxt_s;
    logic [NLINKS-1:0]  stale_mask_r;
    logic               bus_valid_r;
    logic               busy_r;
    logic               overrun_r;
    logic               cap_vld_s;
    logic               cap_fresh_s;
    logic [ADDR_W-1:0]  cap_addr_s;
    logic               drain_done_s;

    assign cap_vld_s   = pipe_vld_r[RD_LAT-1];
    assign cap_addr_s  = pipe_addr_r[RD_LAT-1];
    assign cap_fresh_s = bus.rd_data[UDC_W];

    // Tag pipeline matching the buffer read latency; its last stage marks the returning word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_r <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) pipe_addr_r[i] <= {ADDR_W{1'b0}};
        end else begin
            pipe_vld_r[0]  <= rd_en_r;
            pipe_addr_r[0] <= addr_r;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_addr_r[i] <= pipe_addr_r[i-1];
            end
        end
    end

    // Drain completes when only the final stage can still hold a word.
    always_comb begin
        drain_done_s = ~rd_en_r;
        for (int i = 0; i < RD_LAT - 1; i++) drain_done_s = drain_done_s & ~pipe_vld_r[i];
    end

    for (genvar i = 0; i < NLINKS; i++) begin : g_link
        assign hit_s[i] = cap_vld_s && (cap_addr_s == ADDR_W'(i));
        udc_link_age #(.STALE_MAX(STALE_MAX)) u_age (
            .clk   (clk),
            .rst_n (rst_n),
            .hit   (hit_s[i]),
            .fresh (cap_fresh_s),
            .stale (stale_nxt_s[i])
        );
    end

    // Shadow with this cycle's capture merged in; stale words keep the last good value.
    always_comb begin
        for (int i = 0; i < NLINKS; i++) begin
            if (hit_s[i] && cap_fresh_s) begin
                shadow_nxt_s[i] = bus.rd_data[UDC_W-1:0];
            end else begin
                shadow_nxt_s[i] = shadow_r[i];
            end
        end
    end

    // Pack the merged shadow into per-phase buses, link 1 in the top slice.
    always_comb begin
        for (int p = 0; p < PHASES; p++) begin
            bus_nxt_s[p] = {BUS_W{1'b0}};
            for (int n = 1; n <= LINKNUM; n++) begin
                bus_nxt_s[p][udc_slice_lsb(n) +: UDC_W] = shadow_nxt_s[p*LINKNUM + n - 1];
            end
        end
    end

    // Shadow registers; cleared on reset so nothing from an aborted period survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NLINKS; i++) shadow_r[i] <= {UDC_W{1'b0}};
        end else begin
            shadow_r <= shadow_nxt_s;
        end
    end

    // Sequencer FSM with all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            addr_r       <= {ADDR_W{1'b0}};
            rd_en_r      <= 1'b0;
            busy_r       <= 1'b0;
            bus_valid_r  <= 1'b0;
            overrun_r    <= 1'b0;
            stale_mask_r <= {NLINKS{1'b1}};
            for (int p = 0; p < PHASES; p++) bus_r[p] <= {BUS_W{1'b0}};
        end else begin
            bus_valid_r <= 1'b0;
            overrun_r   <= bus.sync_pulse && (state_r != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (bus.sync_pulse) begin
                        state_r <= ST_READ;
                        addr_r  <= {ADDR_W{1'b0}};
                        rd_en_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (addr_r == LAST_ADDR) begin
                        rd_en_r <= 1'b0;
                        state_r <= ST_DRAIN;
                    end else begin
                        addr_r <= addr_r + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // The last word is merged and published on the same edge.
                    if (drain_done_s) begin
                        state_r      <= ST_PUBLISH;
                        bus_r        <= bus_nxt_s;
                        stale_mask_r <= stale_nxt_s;
                        bus_valid_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_PUBLISH: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    rd_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_en        = rd_en_r;
    assign bus.rd_addr      = addr_r;
    assign bus.LinkUdcA_BUS = bus_r[0];
    assign bus.LinkUdcB_BUS = bus_r[1];
    assign bus.LinkUdcC_BUS = bus_r[2];
    assign bus.bus_valid    = bus_valid_r;
    assign bus.busy         = busy_r;
    assign bus.stale_mask   = stale_mask_r;
    assign bus.overrun      = overrun_r;

endmodule

// File: tb/tb_udc_bus_scheduler.sv
// Directed bench for udc_bus_scheduler: per-period vector table plus overrun, reset and back-to-back sequences.
module tb_udc_bus_scheduler;
    import udc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic sync;
    logic sync4;

    always #5 clk = ~clk;

    udc_bus_scheduler_if bif();
    udc_bus_scheduler_if bif4();

    udc_bus_scheduler #(.LINKNUM(24), .RD_LAT(2), .STALE_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif.master));
    udc_bus_scheduler #(.LINKNUM(24), .RD_LAT(4), .STALE_MAX(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bif4.master));

    logic [15:0] mem_val   [72];
    logic        mem_fresh [72];

    // Link-receive buffer models, latency 2 and 4; junk is returned when no read is due.
    logic       pv  [2];
    logic [6:0] pa  [2];
    logic       pv4 [4];
    logic [6:0] pa4 [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin pv[i] <= 1'b0; pa[i] <= 7'd0; end
            for (int i = 0; i < 4; i++) begin pv4[i] <= 1'b0; pa4[i] <= 7'd0; end
        end else begin
            pv[0] <= bif.rd_en;   pa[0] <= bif.rd_addr;
            pv[1] <= pv[0];       pa[1] <= pa[0];
            pv4[0] <= bif4.rd_en; pa4[0] <= bif4.rd_addr;
            for (int i = 1; i < 4; i++) begin pv4[i] <= pv4[i-1]; pa4[i] <= pa4[i-1]; end
        end
    end

    assign bif.sync_pulse  = sync;
    assign bif4.sync_pulse = sync4;
    assign bif.rd_data  = (pv[1]  && pa[1]  < 7'd72) ? {mem_fresh[pa[1]],  mem_val[pa[1]]}  : 17'h1FFFF;
    assign bif4.rd_data = (pv4[3] && pa4[3] < 7'd72) ? {mem_fresh[pa4[3]], mem_val[pa4[3]]} : 17'h1FFFF;

    typedef struct {
        logic [15:0] base;
        logic        b5_fresh;
        logic [15:0] exp_a1;
        logic [15:0] exp_c24;
        logic [15:0] exp_b5;
        logic [71:0] exp_stale;
    } vec_t;

    vec_t vecs [10];
    int n_vec = 0;
    int n_err = 0;

    int bv_first, bv_second, bv4_first, bv_cnt, rden_cnt, ov_cnt, ov_first;
    logic busy_c0, busy_c1, busy_c75, busy_c76;

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_mem(input logic [15:0] base, input logic b5f);
        for (int a = 0; a < 72; a++) begin
            mem_val[a]   = base + 16'(a);
            mem_fresh[a] = 1'b1;
        end
        mem_fresh[28] = b5f;
    endtask

    // Cycle 0 carries the sync pulse; outputs are sampled 1 time unit after each rising edge.
    task automatic run_seq(input int sync2_at, input int rst_at, input int rst_len,
                           input int ncyc, input bit use4);
        bv_first = -1; bv_second = -1; bv4_first = -1;
        bv_cnt = 0; rden_cnt = 0; ov_cnt = 0; ov_first = -1;
        @(posedge clk); #1;
        sync = 1'b1; sync4 = use4; busy_c0 = bif.busy;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            sync  = (c == sync2_at);
            sync4 = 1'b0;
            if (rst_at > 0 && c == rst_at) rst_n = 1'b0;
            if (rst_at > 0 && c == rst_at + rst_len) rst_n = 1'b1;
            if (bif.bus_valid) begin
                bv_cnt++;
                if (bv_first < 0) bv_first = c;
                else if (bv_second < 0) bv_second = c;
            end
            if (bif4.bus_valid && bv4_first < 0) bv4_first = c;
            if (bif.rd_en) rden_cnt++;
            if (bif.overrun) begin
                ov_cnt++;
                if (ov_first < 0) ov_first = c;
            end
            if (c == 1)  busy_c1  = bif.busy;
            if (c == 75) busy_c75 = bif.busy;
            if (c == 76) busy_c76 = bif.busy;
        end
        sync = 1'b0;
    endtask

    logic [383:0] exp_bus [3];
    logic [15:0]  v;
    int           a;

    initial begin
        vecs[0] = '{16'h0100, 1'b1, 16'h0100, 16'h0147, 16'h011C, 72'h0};
        vecs[1] = '{16'h0200, 1'b0, 16'h0200, 16'h0247, 16'h011C, 72'h0};
        vecs[2] = '{16'h0300, 1'b0, 16'h0300, 16'h0347, 16'h011C, 72'h0};
        vecs[3] = '{16'h0400, 1'b0, 16'h0400, 16'h0447, 16'h011C, 72'h0};
        vecs[4] = '{16'h0500, 1'b0, 16'h0500, 16'h0547, 16'h011C, 72'h0};
        vecs[5] = '{16'h0600, 1'b0, 16'h0600, 16'h0647, 16'h011C, 72'h0};
        vecs[6] = '{16'h0700, 1'b0, 16'h0700, 16'h0747, 16'h011C, 72'h0};
        vecs[7] = '{16'h0800, 1'b0, 16'h0800, 16'h0847, 16'h011C, 72'h0};
        vecs[8] = '{16'h0900, 1'b0, 16'h0900, 16'h0947, 16'h011C, 72'h00_0000_0000_1000_0000};
        vecs[9] = '{16'h0A00, 1'b1, 16'h0A00, 16'h0A47, 16'h0A1C, 72'h0};

        rst_n = 1'b0; sync = 1'b0; sync4 = 1'b0;
        set_mem(16'h0000, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("reset_busA",      bif.LinkUdcA_BUS, 384'h0);
        chk("reset_busC",      bif.LinkUdcC_BUS, 384'h0);
        chk("reset_stale",     bif.stale_mask,   {312'h0, 72'hFF_FFFF_FFFF_FFFF_FFFF});
        chk("reset_bus_valid", bif.bus_valid,    384'h0);
        chk("reset_busy",      bif.busy,         384'h0);
        chk("reset_rd_en",     bif.rd_en,        384'h0);
        chk("reset_rd_addr",   bif.rd_addr,      384'h0);
        chk("reset_stale4",    bif4.stale_mask,  {312'h0, 72'hFF_FFFF_FFFF_FFFF_FFFF});

        for (int k = 0; k < 10; k++) begin
            set_mem(vecs[k].base, vecs[k].b5_fresh);
            run_seq(0, 0, 0, 80, 1'b1);
            for (int p = 0; p < 3; p++) begin
                exp_bus[p] = 384'h0;
                for (int n = 1; n <= 24; n++) begin
                    a = p * 24 + n - 1;
                    v = (a == 28) ? vecs[k].exp_b5 : vecs[k].base + 16'(a);
                    exp_bus[p][384 - 16*n +: 16] = v;
                end
            end
            chk($sformatf("v%0d_bv_cycle", k),  bv_first,  75);
            chk($sformatf("v%0d_bv_count", k),  bv_cnt,    1);
            chk($sformatf("v%0d_rden_cnt", k),  rden_cnt,  72);
            chk($sformatf("v%0d_bv4_cycle", k), bv4_first, 77);
            chk($sformatf("v%0d_a1", k),  bif.LinkUdcA_BUS[383:368], vecs[k].exp_a1);
            chk($sformatf("v%0d_c24", k), bif.LinkUdcC_BUS[15:0],    vecs[k].exp_c24);
            chk($sformatf("v%0d_b5", k),  bif.LinkUdcB_BUS[319:304], vecs[k].exp_b5);
            chk($sformatf("v%0d_busA", k), bif.LinkUdcA_BUS, exp_bus[0]);
            chk($sformatf("v%0d_busB", k), bif.LinkUdcB_BUS, exp_bus[1]);
            chk($sformatf("v%0d_busC", k), bif.LinkUdcC_BUS, exp_bus[2]);
            chk($sformatf("v%0d_stale", k), bif.stale_mask, vecs[k].exp_stale);
            chk($sformatf("v%0d_c24_lat4", k), bif4.LinkUdcC_BUS[15:0], vecs[k].exp_c24);
            chk($sformatf("v%0d_stale_lat4", k), bif4.stale_mask, vecs[k].exp_stale);
        end

        // Second sync while busy: dropped, flagged one cycle later.
        set_mem(16'h0B00, 1'b1);
        run_seq(40, 0, 0, 80, 1'b0);
        chk("ovr_first",   ov_first, 41);
        chk("ovr_count",   ov_cnt,   1);
        chk("ovr_bv_cnt",  bv_cnt,   1);
        chk("ovr_bv_cyc",  bv_first, 75);
        chk("ovr_rden",    rden_cnt, 72);
        chk("ovr_busy0",   busy_c0,  1'b0);
        chk("ovr_busy1",   busy_c1,  1'b1);
        chk("ovr_busy75",  busy_c75, 1'b1);
        chk("ovr_busy76",  busy_c76, 1'b0);
        chk("ovr_a1",      bif.LinkUdcA_BUS[383:368], 16'h0B00);

        // Back-to-back: the earliest legal second sync is accepted.
        run_seq(76, 0, 0, 160, 1'b0);
        chk("b2b_bv_first",  bv_first,  75);
        chk("b2b_bv_second", bv_second, 151);
        chk("b2b_bv_cnt",    bv_cnt,    2);
        chk("b2b_ov_cnt",    ov_cnt,    0);
        chk("b2b_rden",      rden_cnt,  144);

        // Reset mid-READ aborts the period and clears everything.
        set_mem(16'h0C00, 1'b1);
        run_seq(0, 30, 5, 80, 1'b0);
        chk("rst_bv_cnt", bv_cnt, 0);
        chk("rst_busA",   bif.LinkUdcA_BUS, 384'h0);
        chk("rst_busB",   bif.LinkUdcB_BUS, 384'h0);
        chk("rst_stale",  bif.stale_mask, {312'h0, 72'hFF_FFFF_FFFF_FFFF_FFFF});
        chk("rst_busy",   bif.busy,  1'b0);
        chk("rst_rd_en",  bif.rd_en, 1'b0);

        run_seq(0, 0, 0, 80, 1'b0);
        chk("post_rst_bv_cyc", bv_first, 75);
        chk("post_rst_a1",     bif.LinkUdcA_BUS[383:368], 16'h0C00);
        chk("post_rst_c24",    bif.LinkUdcC_BUS[15:0],    16'h0C47);
        chk("post_rst_stale",  bif.stale_mask, 72'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
